mem_arb: RTL and testbench

Two-port memory arbiter between the instruction fetch unit and the load/store execution unit, in front of the single shared memory bus. It grants one requester at a time with round-robin priority and keeps a single transaction outstanding. It routes the response back to the owner, and drops an in-flight fetch response when `flush` is asserted. It sits between the core's decoupled memory ports and the bus master.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/mem_arb.sv | 147 ++++++++++++++
 tb/tb_mem_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter.
//   mreq_t          - memory request {a, we, be, d}. It is used by the fetch unit,
//                     the LSU and the memory bus.
//   mem_arb_state_t - arbiter FSM states.
//   PORT_IF/PORT_LS - requester indices (0 = fetch, 1 = LSU).
package mem_arb_pkg;

   typedef struct packed {
      logic [31:0] a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] d;
   } mreq_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } mem_arb_state_t;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
//   valid_i[1:0] - requester valid bits
//   prio_i       - index that wins when both are valid
//   grant_o[1:0] - one-hot grant (all zero when nothing is valid)
//   any_o        - at least one requester is valid
module rr_pick2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   output logic [1:0] grant_o,
   output logic       any_o
);

   // The only requester wins outright; a tie goes to prio_i.
   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = prio_i ? 2'b10 : 2'b01;
         default: grant_o = 2'b00;
      endcase
      any_o = |valid_i;
   end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter between fetch (port 0) and LSU (port 1).
// It connects them to a single memory bus and keeps one transaction outstanding.
//   clk_i, rst_i                  - clock, synchronous active-high reset
//   if_req_*  / ls_req_*          - decoupled request inputs (mreq_t)
//   if_resp_* / ls_resp_*         - decoupled response outputs (32-bit data)
//   bus_req_*                     - decoupled request to memory (mreq_t)
//   bus_resp_*                    - decoupled response from memory (32-bit)
//   flush_i                       - discards a fetch-owned transaction's response
//                                   and blocks fetch from winning in IDLE
module mem_arb
   import mem_arb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_valid_i,
   output logic        if_req_ready_o,
   input  mreq_t       if_req_data_i,
   output logic        if_resp_valid_o,
   input  logic        if_resp_ready_i,
   output logic [31:0] if_resp_data_o,
   input  logic        ls_req_valid_i,
   output logic        ls_req_ready_o,
   input  mreq_t       ls_req_data_i,
   output logic        ls_resp_valid_o,
   input  logic        ls_resp_ready_i,
   output logic [31:0] ls_resp_data_o,
   output logic        bus_req_valid_o,
   input  logic        bus_req_ready_i,
   output mreq_t       bus_req_data_o,
   input  logic        bus_resp_valid_i,
   output logic        bus_resp_ready_o,
   input  logic [31:0] bus_resp_data_i,
   input  logic        flush_i
);

   mem_arb_state_t state_q, state_d;
   logic           prio_q, prio_d;
   logic           owner_q, owner_d;
   logic           drop_q, drop_d;
   mreq_t          req_q, req_d;

   logic [1:0]     pick_valid_s;
   logic [1:0]     grant_s;
   logic           any_s;
   logic           drop_now_s;
   logic           resp_ready_s;

   // A flush in IDLE keeps fetch out of this cycle's arbitration.
   assign pick_valid_s = {ls_req_valid_i, if_req_valid_i & ~flush_i};

   // A flush counts in the cycle it is raised, so a response that arrives together
   // with the flush is discarded too.
   assign drop_now_s = drop_q | (flush_i & (owner_q == PORT_IF));

   rr_pick2 u_pick (
      .valid_i (pick_valid_s),
      .prio_i  (prio_q),
      .grant_o (grant_s),
      .any_o   (any_s)
   );

   // Next-state and handshake outputs; while rst_i is high no handshake is offered.
   always_comb begin
      state_d          = state_q;
      prio_d           = prio_q;
      owner_d          = owner_q;
      drop_d           = drop_q;
      req_d            = req_q;
      resp_ready_s     = 1'b0;
      if_req_ready_o   = 1'b0;
      ls_req_ready_o   = 1'b0;
      if_resp_valid_o  = 1'b0;
      ls_resp_valid_o  = 1'b0;
      if_resp_data_o   = 32'h0;
      ls_resp_data_o   = 32'h0;
      bus_req_valid_o  = 1'b0;
      bus_req_data_o   = req_q;
      if (rst_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               drop_d = 1'b0;
               if (any_s) begin
                  if_req_ready_o = grant_s[0];
                  ls_req_ready_o = grant_s[1];
                  req_d          = grant_s[1] ? ls_req_data_i : if_req_data_i;
                  owner_d        = grant_s[1];
                  prio_d         = ~grant_s[1];
                  state_d        = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               bus_req_valid_o = 1'b1;
               drop_d          = drop_now_s;
               if (bus_req_ready_i) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
            ST_WAIT: begin
               if (owner_q == PORT_LS) begin
                  ls_resp_valid_o = bus_resp_valid_i;
                  ls_resp_data_o  = bus_resp_data_i;
                  resp_ready_s    = ls_resp_ready_i;
               end else begin
                  if_resp_valid_o = bus_resp_valid_i & ~drop_now_s;
                  if_resp_data_o  = bus_resp_data_i;
                  resp_ready_s    = drop_now_s | if_resp_ready_i;
               end
               if (bus_resp_valid_i && resp_ready_s) begin
                  drop_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  drop_d  = drop_now_s;
                  state_d = ST_WAIT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      bus_resp_ready_o = resp_ready_s;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         drop_q  <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         drop_q  <= drop_d;
         req_q   <= req_d;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
   import mem_arb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_valid_i, if_req_ready_o;
   mreq_t       if_req_data_i;
   logic        if_resp_valid_o, if_resp_ready_i;
   logic [31:0] if_resp_data_o;
   logic        ls_req_valid_i, ls_req_ready_o;
   mreq_t       ls_req_data_i;
   logic        ls_resp_valid_o, ls_resp_ready_i;
   logic [31:0] ls_resp_data_o;
   logic        bus_req_valid_o, bus_req_ready_i;
   mreq_t       bus_req_data_o;
   logic        bus_resp_valid_i, bus_resp_ready_o;
   logic [31:0] bus_resp_data_i;
   logic        flush_i;

   mem_arb dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o), .if_req_data_i(if_req_data_i),
      .if_resp_valid_o(if_resp_valid_o), .if_resp_ready_i(if_resp_ready_i), .if_resp_data_o(if_resp_data_o),
      .ls_req_valid_i(ls_req_valid_i), .ls_req_ready_o(ls_req_ready_o), .ls_req_data_i(ls_req_data_i),
      .ls_resp_valid_o(ls_resp_valid_o), .ls_resp_ready_i(ls_resp_ready_i), .ls_resp_data_o(ls_resp_data_o),
      .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i), .bus_req_data_o(bus_req_data_o),
      .bus_resp_valid_i(bus_resp_valid_i), .bus_resp_ready_o(bus_resp_ready_o), .bus_resp_data_i(bus_resp_data_i),
      .flush_i(flush_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction-level reference: is a transaction outstanding? Has the bus taken it?
   // Who owns it, and is its response to be discarded?
   logic  out_m, issued_m, owner_m, prio_m, drop_m;
   mreq_t req_m;
   int    n_drop;
   int    grant_log[$];
   logic [31:0] addr_log[$];

   task automatic check_eq(input string tag, input logic [68:0] obs, input logic [68:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic mreq_t mk_req(input logic [31:0] a);
      mreq_t r;
      r.a = a; r.we = 1'b0; r.be = 4'hF; r.d = 32'h0;
      return r;
   endfunction

   function automatic mreq_t rand_req();
      mreq_t r;
      r.a = $urandom; r.we = 1'($urandom_range(1, 0)); r.be = 4'($urandom); r.d = $urandom;
      return r;
   endfunction

   // Monitor: predict every handshake signal from the arbitration rules and
   // advance the transaction model by what happens at the coming posedge.
   initial begin : monitor
      logic cand_if, cand_ls, exp_ifr, exp_lsr, waiting, dropping;
      logic exp_ifv, exp_lsv, exp_brdy;
      out_m = 1'b0; issued_m = 1'b0; owner_m = 1'b0; prio_m = 1'b0; drop_m = 1'b0;
      req_m = '0; n_drop = 0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            check_eq("rst_if_req_ready", if_req_ready_o, 1'b0);
            check_eq("rst_ls_req_ready", ls_req_ready_o, 1'b0);
            check_eq("rst_bus_req_valid", bus_req_valid_o, 1'b0);
            check_eq("rst_bus_resp_ready", bus_resp_ready_o, 1'b0);
            check_eq("rst_if_resp_valid", if_resp_valid_o, 1'b0);
            check_eq("rst_ls_resp_valid", ls_resp_valid_o, 1'b0);
            out_m = 1'b0; issued_m = 1'b0; prio_m = 1'b0; drop_m = 1'b0; owner_m = 1'b0;
         end else begin
            cand_if = if_req_valid_i && !flush_i;
            cand_ls = ls_req_valid_i;
            exp_ifr = !out_m && cand_if && (!cand_ls || prio_m == 1'b0);
            exp_lsr = !out_m && cand_ls && (!cand_if || prio_m == 1'b1);
            check_eq("if_req_ready", if_req_ready_o, exp_ifr);
            check_eq("ls_req_ready", ls_req_ready_o, exp_lsr);
            check_eq("bus_req_valid", bus_req_valid_o, out_m && !issued_m);
            if (out_m && !issued_m) check_eq("bus_req_data", bus_req_data_o, req_m);
            waiting  = out_m && issued_m;
            dropping = waiting && owner_m == 1'b0 && (drop_m || flush_i);
            exp_ifv  = waiting && owner_m == 1'b0 && !dropping && bus_resp_valid_i;
            exp_lsv  = waiting && owner_m == 1'b1 && bus_resp_valid_i;
            exp_brdy = waiting && (dropping || (owner_m ? ls_resp_ready_i : if_resp_ready_i));
            check_eq("if_resp_valid", if_resp_valid_o, exp_ifv);
            check_eq("ls_resp_valid", ls_resp_valid_o, exp_lsv);
            check_eq("bus_resp_ready", bus_resp_ready_o, exp_brdy);
            if (exp_ifv) check_eq("if_resp_data", if_resp_data_o, bus_resp_data_i);
            if (exp_lsv) check_eq("ls_resp_data", ls_resp_data_o, bus_resp_data_i);
            if (!out_m) begin
               if (exp_ifr || exp_lsr) begin
                  out_m = 1'b1; issued_m = 1'b0; drop_m = 1'b0;
                  owner_m = exp_lsr;
                  req_m = exp_lsr ? ls_req_data_i : if_req_data_i;
                  prio_m = !exp_lsr;
                  grant_log.push_back(exp_lsr ? 1 : 0);
               end
            end else if (!issued_m) begin
               if (flush_i && owner_m == 1'b0) drop_m = 1'b1;
               if (bus_req_ready_i) begin
                  issued_m = 1'b1;
                  addr_log.push_back(bus_req_data_o.a);
               end
            end else begin
               if (bus_resp_valid_i && exp_brdy) begin
                  if (dropping) n_drop++;
                  out_m = 1'b0; issued_m = 1'b0; drop_m = 1'b0;
               end else if (flush_i && owner_m == 1'b0) begin
                  drop_m = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      if_req_valid_i = 1'b0; ls_req_valid_i = 1'b0;
      if_req_data_i = '0; ls_req_data_i = '0;
      if_resp_ready_i = 1'b0; ls_resp_ready_i = 1'b0;
      bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b0; bus_resp_data_i = 32'h0;
      flush_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
   endtask

   task automatic drain();
      int k;
      if_req_valid_i = 1'b0; ls_req_valid_i = 1'b0; flush_i = 1'b0;
      bus_req_ready_i = 1'b1; bus_resp_valid_i = 1'b1;
      if_resp_ready_i = 1'b1; ls_resp_ready_i = 1'b1;
      k = 0;
      while (out_m && k < 20) begin tick(); k++; end
      check_eq("drain_done", out_m, 1'b0);
      idle_inputs();
   endtask

   initial begin : stim
      int k, d0;
      do_reset();
      #1;
      check_eq("reset_bus_req_data", bus_req_data_o, 69'd0);
      check_eq("reset_bus_req_valid", bus_req_valid_o, 1'b0);

      // LSU load, bus ready, response one cycle later.
      ls_req_valid_i = 1'b1; ls_req_data_i = mk_req(32'h100);
      bus_req_ready_i = 1'b1; ls_resp_ready_i = 1'b1;
      tick();
      ls_req_valid_i = 1'b0;
      #1 check_eq("t1_bus_req_a", bus_req_data_o.a, 32'h100);
      tick();
      bus_resp_valid_i = 1'b1; bus_resp_data_i = 32'hDEADBEEF;
      #1;
      check_eq("t1_ls_resp_valid", ls_resp_valid_o, 1'b1);
      check_eq("t1_ls_resp_data", ls_resp_data_o, 32'hDEADBEEF);
      check_eq("t1_if_resp_valid", if_resp_valid_o, 1'b0);
      tick();
      bus_resp_valid_i = 1'b0; ls_req_valid_i = 1'b1;
      #1 check_eq("t1_back_to_idle", ls_req_ready_o, 1'b1);
      tick();
      drain();

      // Both ports continuously valid: fetch, LSU, fetch, LSU at full rate.
      do_reset();
      grant_log.delete(); addr_log.delete();
      if_req_valid_i = 1'b1; if_req_data_i = mk_req(32'h0);
      ls_req_valid_i = 1'b1; ls_req_data_i = mk_req(32'h200);
      bus_req_ready_i = 1'b1; bus_resp_valid_i = 1'b1;
      if_resp_ready_i = 1'b1; ls_resp_ready_i = 1'b1;
      k = 0;
      while (grant_log.size() < 4 && k < 40) begin tick(); k++; end
      check_eq("t2_cycles_for_4", 69'(k), 69'd10);
      drain();
      check_eq("t2_log_size", 69'(addr_log.size()), 69'd4);
      if (addr_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check_eq("t2_grant_order", 69'(grant_log[i]), 69'(i % 2));
            check_eq("t2_bus_addr", 69'(addr_log[i]), (i % 2 == 1) ? 69'h200 : 69'h0);
         end
      end

      // Fetch owns WAIT; flush arrives with the response; LSU follows next cycle.
      do_reset();
      d0 = n_drop;
      if_req_valid_i = 1'b1; if_req_data_i = mk_req(32'h40); bus_req_ready_i = 1'b1;
      tick();
      if_req_valid_i = 1'b0;
      tick();
      flush_i = 1'b1; bus_resp_valid_i = 1'b1; bus_resp_data_i = 32'h12345678;
      if_resp_ready_i = 1'b0; ls_req_valid_i = 1'b1; ls_req_data_i = mk_req(32'h300);
      #1;
      check_eq("t4_bus_resp_ready", bus_resp_ready_o, 1'b1);
      check_eq("t4_if_resp_valid", if_resp_valid_o, 1'b0);
      check_eq("t4_ls_not_granted", ls_req_ready_o, 1'b0);
      tick();
      flush_i = 1'b0; bus_resp_valid_i = 1'b0;
      #1 check_eq("t4_ls_granted", ls_req_ready_o, 1'b1);
      tick();
      drain();
      check_eq("t4_dropped", 69'(n_drop - d0), 69'd1);

      // LSU owns WAIT with its response port stalled for two cycles.
      do_reset();
      ls_req_valid_i = 1'b1; ls_req_data_i = mk_req(32'h500); bus_req_ready_i = 1'b1;
      tick();
      ls_req_valid_i = 1'b0;
      tick();
      bus_resp_valid_i = 1'b1; bus_resp_data_i = 32'hCAFE0001; ls_resp_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1 check_eq("t5_stall_ready", bus_resp_ready_o, 1'b0);
         tick();
      end
      ls_resp_ready_i = 1'b1;
      #1 check_eq("t5_complete_ready", bus_resp_ready_o, 1'b1);
      tick();
      bus_resp_valid_i = 1'b0;
      #1 check_eq("t5_idle", out_m, 1'b0);

      // Reset in the middle of ISSUE.
      do_reset();
      if_req_valid_i = 1'b1; if_req_data_i = mk_req(32'h80); ls_req_valid_i = 1'b1;
      ls_req_data_i = mk_req(32'h90); bus_req_ready_i = 1'b0;
      tick();
      if_req_valid_i = 1'b0; ls_req_valid_i = 1'b0;
      tick();
      rst_i = 1'b1;
      #1 check_eq("t6_rst_bus_valid", bus_req_valid_o, 1'b0);
      tick();
      rst_i = 1'b0;
      #1 check_eq("t6_after_bus_valid", bus_req_valid_o, 1'b0);
      if_req_valid_i = 1'b1; ls_req_valid_i = 1'b1;
      #1;
      check_eq("t6_prio_fetch", if_req_ready_o, 1'b1);
      check_eq("t6_prio_ls", ls_req_ready_o, 1'b0);
      tick();
      drain();

      // Randomized traffic with occasional flushes and resets.
      for (int c = 0; c < 3000; c++) begin
         rst_i = ($urandom_range(255, 0) == 0);
         if_req_valid_i = 1'($urandom_range(1, 0));
         ls_req_valid_i = 1'($urandom_range(1, 0));
         if_req_data_i = rand_req();
         ls_req_data_i = rand_req();
         flush_i = ($urandom_range(7, 0) == 0);
         bus_req_ready_i = 1'($urandom_range(1, 0));
         bus_resp_valid_i = out_m && issued_m && ($urandom_range(1, 0) == 1);
         bus_resp_data_i = $urandom;
         if_resp_ready_i = ($urandom_range(9, 0) < 7);
         ls_resp_ready_i = ($urandom_range(9, 0) < 7);
         tick();
      end
      rst_i = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
